// File: rtl/c17_bist_sequencer_if.sv
// Handshake and datapath bundle between the BIST sequencer,
// its test-access controller and the C17 core.
interface c17_bist_sequencer_if;
    logic       start;
    logic       abort;
    logic [4:0] pat;
    logic       resp22;
    logic       resp23;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] cnt22;
    logic [5:0] cnt23;

    // Environment side: control requests and core responses.
    modport master (
        output start, abort, resp22, resp23,
        input  pat, busy, done, pass, cnt22, cnt23
    );

    // Sequencer side.
    modport slave (
        input  start, abort, resp22, resp23,
        output pat, busy, done, pass, cnt22, cnt23
    );
endinterface

// File: rtl/c17_bist_sequencer.sv
// Exhaustive BIST sequencer for the C17 core: walks all 32 vectors,
// counts ones on both outputs and compares against golden counts.
module c17_bist_sequencer #(
    parameter int unsigned RESP_LAT = 1,
    parameter int unsigned EXP22    = 18,
    parameter int unsigned EXP23    = 18
) (
    input  logic clock,
    input  logic reset,
    c17_bist_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // With zero latency the DRIVE phase vanishes entirely.
    localparam state_t FIRST =
        (RESP_LAT == 0) ? SAMPLE : DRIVE;
    localparam logic [3:0] WAIT_LAST =
        4'((RESP_LAT == 0) ? 0 : RESP_LAT - 1);
    localparam logic [5:0] GOLD22 = 6'(EXP22);
    localparam logic [5:0] GOLD23 = 6'(EXP23);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [4:0] pat_q, pat_d;
    logic [5:0] c22_q, c22_d;
    logic [5:0] c23_q, c23_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] sum22, sum23;
    logic       kill, go;

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pat_d   = pat_q;
        c22_d   = c22_q;
        c23_d   = c23_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        sum22   = c22_q + {5'd0, bus.resp22};
        sum23   = c23_q + {5'd0, bus.resp23};
        kill    = bus.abort && (state_q != IDLE);
        go      = bus.start && !bus.abort &&
                  ((state_q == IDLE) ||
                   (state_q == DONE));

        unique case (state_q)
            IDLE: begin
                pat_d = 5'd0;
            end
            DRIVE: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 4'd0;
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            SAMPLE: begin
                c22_d = sum22;
                c23_d = sum23;
                if (pat_q == 5'd31) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (sum22 == GOLD22) &&
                              (sum23 == GOLD23);
                end else begin
                    pat_d   = pat_q + 5'd1;
                    state_d = FIRST;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (kill) begin
            state_d = IDLE;
            wait_d  = 4'd0;
            pat_d   = 5'd0;
            c22_d   = 6'd0;
            c23_d   = 6'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else if (go) begin
            state_d = FIRST;
            wait_d  = 4'd0;
            pat_d   = 5'd0;
            c22_d   = 6'd0;
            c23_d   = 6'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            pat_q   <= 5'd0;
            c22_q   <= 6'd0;
            c23_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pat_q   <= pat_d;
            c22_q   <= c22_d;
            c23_q   <= c23_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.pat   = pat_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.pass  = pass_q;
    assign bus.cnt22 = c22_q;
    assign bus.cnt23 = c23_q;

endmodule

// File: tb/tb_c17_bist_sequencer.sv
// Bench for the C17 BIST sequencer: golden runs, injected faults,
// abort, ignored start, async reset and restart.
module tb_c17_bist_sequencer;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   f22    = 0;
    int   f23    = 0;
    logic r22, r23;

    c17_bist_sequencer_if b1 ();
    c17_bist_sequencer_if b0 ();

    c17_bist_sequencer #(
        .RESP_LAT(1), .EXP22(18), .EXP23(18)
    ) dut (
        .clock(clock), .reset(reset), .bus(b1)
    );

    c17_bist_sequencer #(
        .RESP_LAT(0), .EXP22(18), .EXP23(18)
    ) dut0 (
        .clock(clock), .reset(reset), .bus(b0)
    );

    // Reference C17 netlist: bit0 = 22gat, bit1 = 23gat.
    function automatic logic [1:0] c17(input logic [4:0] p);
        logic g1, g2, g3, g6, g7;
        logic n10, n11, n16, n19;
        g1  = p[4]; g2 = p[3]; g3 = p[2];
        g6  = p[1]; g7 = p[0];
        n10 = ~(g1 & g3);
        n11 = ~(g3 & g6);
        n16 = ~(g2 & n11);
        n19 = ~(n11 & g7);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    // Expected ones-count: f=0 healthy, 1 stuck-at-0, 2 stuck-at-1.
    function automatic int ref_count(input int sel, input int f);
        int s = 0;
        logic [1:0] r;
        for (int p = 0; p < 32; p++) begin
            r = c17(5'(p));
            if (f == 0)      s += int'(r[sel]);
            else if (f == 2) s += 1;
        end
        return s;
    endfunction

    // Core with a one-cycle registered response.
    always_ff @(posedge clock) begin
        r22 <= c17(b1.pat)[0];
        r23 <= c17(b1.pat)[1];
    end

    assign b1.resp22 = (f22 == 1) ? 1'b0 :
                       (f22 == 2) ? 1'b1 : r22;
    assign b1.resp23 = (f23 == 1) ? 1'b0 :
                       (f23 == 2) ? 1'b1 : r23;
    assign b0.resp22 = c17(b0.pat)[0];
    assign b0.resp23 = c17(b0.pat)[1];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pat"},  32'(b1.pat),   0);
        chk({tag, "_busy"}, 32'(b1.busy),  0);
        chk({tag, "_done"}, 32'(b1.done),  0);
        chk({tag, "_pass"}, 32'(b1.pass),  0);
        chk({tag, "_c22"},  32'(b1.cnt22), 0);
        chk({tag, "_c23"},  32'(b1.cnt23), 0);
    endtask

    task automatic wait_pat(input int v);
        int n = 0;
        while (int'(b1.pat) != v && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("wait_pat", 32'(b1.pat), 32'(v));
    endtask

    // Full run on the latency-1 DUT; optional ignored start at pat=ign.
    task automatic run1(input string tag, input int ign);
        int  n = 0;
        bit  hit = 0;
        int  e22, e23;
        e22 = ref_count(0, f22);
        e23 = ref_count(1, f23);
        b1.start = 1'b1;
        @(negedge clock);
        b1.start = 1'b0;
        chk({tag, "_busy0"}, 32'(b1.busy), 1);
        chk({tag, "_done0"}, 32'(b1.done), 0);
        chk({tag, "_pass0"}, 32'(b1.pass), 0);
        while (b1.busy && n < 200) begin
            b1.start = 1'b0;
            if (!hit && int'(b1.pat) == ign) begin
                b1.start = 1'b1;
                hit = 1;
            end
            n++;
            @(negedge clock);
        end
        b1.start = 1'b0;
        chk({tag, "_len"},  32'(n), 64);
        chk({tag, "_done"}, 32'(b1.done), 1);
        chk({tag, "_c22"},  32'(b1.cnt22), 32'(e22));
        chk({tag, "_c23"},  32'(b1.cnt23), 32'(e23));
        chk({tag, "_pass"}, 32'(b1.pass),
            32'(e22 == 18 && e23 == 18));
    endtask

    initial begin
        b1.start = 1'b0; b1.abort = 1'b0;
        b0.start = 1'b0; b0.abort = 1'b0;
        reset = 1'b1;
        #12;
        chk_idle("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_idle("idle");

        // T1 golden run, then T6 restart from DONE
        run1("t1", -1);
        run1("t6", -1);

        // T6 abort+start together from DONE and from IDLE
        b1.abort = 1'b1; b1.start = 1'b1;
        @(negedge clock);
        chk_idle("abst_done");
        @(negedge clock);
        b1.abort = 1'b0; b1.start = 1'b0;
        chk_idle("abst_idle");
        b1.abort = 1'b1;
        @(negedge clock);
        b1.abort = 1'b0;
        chk_idle("abort_idle");

        // T2 zero-latency DUT: one vector per cycle
        b0.start = 1'b1;
        @(negedge clock);
        b0.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("t2_pat",  32'(b0.pat),  32'(i));
            chk("t2_busy", 32'(b0.busy), 1);
            @(negedge clock);
        end
        chk("t2_busy_end", 32'(b0.busy),  0);
        chk("t2_done",     32'(b0.done),  1);
        chk("t2_c22",      32'(b0.cnt22), 32'(ref_count(0, 0)));
        chk("t2_c23",      32'(b0.cnt23), 32'(ref_count(1, 0)));
        chk("t2_pass",     32'(b0.pass),  1);

        // T3 stuck-at faults
        f22 = 1; f23 = 0;
        run1("t3a", -1);
        f22 = 0; f23 = 2;
        run1("t3b", -1);
        f23 = 0;

        // T4 abort at pat=10, then a run with an ignored start
        b1.start = 1'b1;
        @(negedge clock);
        b1.start = 1'b0;
        wait_pat(10);
        b1.abort = 1'b1;
        @(negedge clock);
        b1.abort = 1'b0;
        chk_idle("t4_abort");
        run1("t4_ign", 5);

        // Abort at a random vector
        b1.start = 1'b1;
        @(negedge clock);
        b1.start = 1'b0;
        wait_pat(int'($urandom_range(1, 30)));
        b1.abort = 1'b1;
        @(negedge clock);
        b1.abort = 1'b0;
        chk_idle("rnd_abort");

        // T5 asynchronous reset between edges at pat=20
        b1.start = 1'b1;
        @(negedge clock);
        b1.start = 1'b0;
        wait_pat(20);
        #2 reset = 1'b1;
        #1 chk_idle("t5_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run1("t5_run", -1);

        // Randomized fault mixes checked against the model
        for (int k = 0; k < 6; k++) begin
            f22 = int'($urandom_range(0, 2));
            f23 = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run1("rnd", -1);
        end
        f22 = 0; f23 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
